// File: rtl/charlieplex_ctrl.sv
// Charlieplexed 7-pin LED matrix driver (7 rows x 6 LEDs) with Wishbone classic register access.
// Row patterns are double-buffered; the active copy is refreshed only when a frame restarts at row 0.
module charlieplex_ctrl #(
  parameter int unsigned STEP  = 64,
  parameter int unsigned BLANK = 16
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       wb_cyc_i,
  input  logic       wb_stb_i,
  input  logic       wb_we_i,
  input  logic [3:0] wb_adr_i,
  input  logic [7:0] wb_dat_i,
  output logic [7:0] wb_dat_o,
  output logic       wb_ack_o,
  output logic [6:0] charlieplex_oe,
  output logic [6:0] charlieplex_o
);

  localparam int unsigned CMAX = (STEP > BLANK) ? STEP : BLANK;
  localparam int unsigned CW   = (CMAX > 1) ? $clog2(CMAX) : 1;

  typedef enum logic [1:0] {S_IDLE, S_ACTIVE, S_BLANK} state_t;
  typedef logic [5:0] row_t;

  row_t        row_regs [7];
  row_t        act_buf  [7];
  logic        en;
  logic [3:0]  bright;
  state_t      state;
  logic [2:0]  row;
  logic [4:0]  frame;
  logic [CW-1:0] cnt;
  logic [3:0]  level;

  logic        bus_req;
  logic [7:0]  rd_data;
  logic        unused_dat;

  assign bus_req    = wb_cyc_i & wb_stb_i & ~wb_ack_o;
  assign unused_dat = ^wb_dat_i[3:1];

  always_comb begin
    rd_data = '0;
    case (wb_adr_i)
      4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6:
        rd_data = {2'b00, row_regs[wb_adr_i[2:0]]};
      4'h7:    rd_data = {bright, 3'b000, en};
      4'h8:    rd_data = {frame, row};
      default: rd_data = '0;
    endcase
  end

  // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wb_ack_o <= 1'b0;
      wb_dat_o <= '0;
      en       <= 1'b0;
      bright   <= '0;
      // NOTE: the shadow rows are a small register file, so they are cleared explicitly on reset.
      for (int i = 0; i < 7; i++) row_regs[i] <= '0;
    end else begin
      wb_ack_o <= bus_req;
      if (bus_req) begin
        wb_dat_o <= rd_data;
        if (wb_we_i) begin
          if (wb_adr_i <= 4'h6) begin
            row_regs[wb_adr_i[2:0]] <= wb_dat_i[5:0];
          end else if (wb_adr_i == 4'h7) begin
            en     <= wb_dat_i[0];
            bright <= wb_dat_i[7:4];
          end
        end
      end
    end
  end

  // Scan sequencer: ACTIVE dwell is 16 brightness levels of STEP clocks, then BLANK all-off clocks.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state <= S_IDLE;
      row   <= '0;
      frame <= '0;
      cnt   <= '0;
      level <= '0;
      for (int i = 0; i < 7; i++) act_buf[i] <= '0;
    end else if (!en) begin
      state <= S_IDLE;
      row   <= '0;
      cnt   <= '0;
      level <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          state   <= S_ACTIVE;
          row     <= '0;
          cnt     <= '0;
          level   <= '0;
          act_buf <= row_regs;
        end
        S_ACTIVE: begin
          if (cnt == CW'(STEP - 1)) begin
            cnt <= '0;
            if (level == 4'd15) begin
              level <= '0;
              state <= S_BLANK;
            end else begin
              level <= level + 4'd1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_BLANK: begin
          if (cnt == CW'(BLANK - 1)) begin
            cnt   <= '0;
            state <= S_ACTIVE;
            if (row == 3'd6) begin
              row     <= '0;
              frame   <= frame + 5'd1;
              act_buf <= row_regs;
            end else begin
              row <= row + 3'd1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  logic [6:0] oe_next, o_next;
  row_t       act_row;

  // Anode on pin `row`; LED bit k sinks through pin k below the anode, pin k+1 at or above it.
  always_comb begin
    // NOTE: every combinational output gets a default first so no latch is inferred.
    oe_next = '0;
    o_next  = '0;
    act_row = '0;
    for (int a = 0; a < 7; a++) begin
      if (row == 3'(a)) act_row = act_buf[a];
    end
    if (en && state == S_ACTIVE) begin
      oe_next[row] = 1'b1;
      o_next[row]  = 1'b1;
      if (level < bright) begin
        for (int k = 0; k < 6; k++) begin
          if (act_row[k]) begin
            if (k < int'(row)) oe_next[k]     = 1'b1;
            else               oe_next[k + 1] = 1'b1;
          end
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      charlieplex_oe <= '0;
      charlieplex_o  <= '0;
    end else begin
      charlieplex_oe <= oe_next;
      charlieplex_o  <= o_next;
    end
  end

endmodule
